// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic operand feeder.
//   - Default array geometry and operand width.
//   - feeder_state_t : feeder sequencing states.
//   - operand_t      : one operand word at the default width.
//   - max2()         : larger of two ints.
//   - addr_width()   : bits needed to address the larger of the A (NxK) and B (KxM) banks.
package systolic_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_N          = 3;
  localparam int DEFAULT_M          = 3;
  localparam int DEFAULT_K          = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] operand_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int addr_width(input int n, input int m, input int k);
    int depth;
    depth = max2(n * k, k * m);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/systolic_operand_feeder_bank.sv
// feeder_bank: operand storage with one synchronous write port and L
// combinational read lanes. Contents are deliberately not reset.
// Ports:
//   clk    in  clock, rising edge
//   we     in  write enable (address already range-checked by the caller)
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  L packed read addresses, lane l = [l*AW +: AW]
//   rdata  out L packed read words,     lane l = [l*DW +: DW]
module feeder_bank #(
  parameter int DW    = 32,
  parameter int DEPTH = 9,
  parameter int L     = 3,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [L*AW-1:0] raddr,
  output logic [L*DW-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr[IW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int l = 0; l < L; l++) begin
      rdata[l*DW +: DW] = mem_q[raddr[l*AW +: IW]];
    end
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder: buffers operand matrices A (NxK) and B (KxM) and, on
// start, streams skewed A rows / B columns with per-lane enables into the
// edge of an NxM systolic MAC array, waits for the array to drain, then
// pulses load_out for one cycle.
// Optional build macro: FEEDER_DOUBLE_BUF_EN (ping-pong banks, writes always
// accepted into the shadow bank, start swaps banks and may restart from DONE).
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-low
//   wr_en     in   operand write strobe
//   wr_sel    in   0 = A bank, 1 = B bank
//   wr_addr   in   A: i*K+k, B: k*M+j; out-of-range writes are dropped
//   wr_data   in   operand value
//   wr_ready  out  write accepted when wr_en & wr_ready
//   start     in   begin streaming
//   busy      out  high in STREAM/DRAIN
//   A_out     out  N lanes of DATA_WIDTH, zero when the lane is disabled
//   A_en      out  per-lane A valid
//   B_out     out  M lanes of DATA_WIDTH, zero when the lane is disabled
//   B_en      out  per-lane B valid
//   load_out  out  one-cycle pulse when array results are final
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N          = DEFAULT_N,
  parameter int M          = DEFAULT_M,
  parameter int K          = DEFAULT_K,
  parameter int DRAIN      = N + M - 1,
  localparam int AW        = addr_width(N, M, K)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_ready,
  input  logic                    start,
  output logic                    busy,
  output logic [N*DATA_WIDTH-1:0] A_out,
  output logic [N-1:0]            A_en,
  output logic [M*DATA_WIDTH-1:0] B_out,
  output logic [M-1:0]            B_en,
  output logic                    load_out
);

  localparam int T       = K + max2(N, M) - 1;
  localparam int CNT_MAX = max2(T, DRAIN);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // The DRAIN parameter hides the state of the same name, so refer to it by package scope.
  localparam feeder_state_t ST_DRAIN = systolic_pkg::DRAIN;

  feeder_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N*DATA_WIDTH-1:0] a_out_q, a_out_d;
  logic [M*DATA_WIDTH-1:0] b_out_q, b_out_d;
  logic [N-1:0]            a_en_q, a_en_d;
  logic [M-1:0]            b_en_q, b_en_d;

  logic [N*AW-1:0]         a_raddr;
  logic [M*AW-1:0]         b_raddr;
  logic [N*DATA_WIDTH-1:0] a_rdata;
  logic [M*DATA_WIDTH-1:0] b_rdata;

  logic wr_in_range, wr_accept, a_we, b_we, bank_match;

  assign wr_in_range = wr_sel ? (32'(wr_addr) < K * M) : (32'(wr_addr) < N * K);
  assign wr_accept   = wr_en & wr_ready & wr_in_range;
  assign a_we        = wr_accept & ~wr_sel;
  assign b_we        = wr_accept & wr_sel;

`ifdef FEEDER_DOUBLE_BUF_EN
  // bank_sel_q names the active bank; writes always go to the other one.
  logic bank_sel_q, bank_sel_d, wr_bank, rd_bank, swap;
  logic [N*DATA_WIDTH-1:0] a_rdata_bank [2];
  logic [M*DATA_WIDTH-1:0] b_rdata_bank [2];

  // A new run begins exactly when the FSM enters STREAM from IDLE or DONE.
  assign swap       = (state_d == STREAM) && ((state_q == IDLE) || (state_q == DONE));
  assign bank_sel_d = swap ? ~bank_sel_q : bank_sel_q;
  assign wr_bank    = ~bank_sel_q;
  assign rd_bank    = bank_sel_d;
  assign bank_match = (wr_bank == rd_bank);
  assign wr_ready   = 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_sel_q <= 1'b0;
    end else begin
      bank_sel_q <= bank_sel_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    feeder_bank #(.DW(DATA_WIDTH), .DEPTH(N * K), .L(N), .AW(AW)) u_a_bank (
      .clk   (clk),
      .we    (a_we & (wr_bank == 1'(g))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (a_raddr),
      .rdata (a_rdata_bank[g])
    );
    feeder_bank #(.DW(DATA_WIDTH), .DEPTH(K * M), .L(M), .AW(AW)) u_b_bank (
      .clk   (clk),
      .we    (b_we & (wr_bank == 1'(g))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (b_raddr),
      .rdata (b_rdata_bank[g])
    );
  end

  assign a_rdata = a_rdata_bank[rd_bank];
  assign b_rdata = b_rdata_bank[rd_bank];
`else
  assign bank_match = 1'b1;
  assign wr_ready   = (state_q == IDLE);

  feeder_bank #(.DW(DATA_WIDTH), .DEPTH(N * K), .L(N), .AW(AW)) u_a_bank (
    .clk   (clk),
    .we    (a_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (a_raddr),
    .rdata (a_rdata)
  );
  feeder_bank #(.DW(DATA_WIDTH), .DEPTH(K * M), .L(M), .AW(AW)) u_b_bank (
    .clk   (clk),
    .we    (b_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (b_raddr),
    .rdata (b_rdata)
  );
`endif

  // Sequencing: cnt counts stream steps in STREAM and drain cycles in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (cnt_q == CW'(T - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CW'(DRAIN - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
`ifdef FEEDER_DOUBLE_BUF_EN
        if (start) begin
          state_d = STREAM;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered, so lane enables and read addresses are derived
  // from the step the array will see next cycle (state_d/cnt_d).
  always_comb begin
    int t;
    t       = int'(cnt_d);
    a_en_d  = '0;
    b_en_d  = '0;
    a_raddr = '0;
    b_raddr = '0;
    if (state_d == STREAM) begin
      for (int i = 0; i < N; i++) begin
        if (t >= i && t < i + K) begin
          a_en_d[i]           = 1'b1;
          a_raddr[i*AW +: AW] = AW'(i * K + (t - i));
        end
      end
      for (int j = 0; j < M; j++) begin
        if (t >= j && t < j + K) begin
          b_en_d[j]           = 1'b1;
          b_raddr[j*AW +: AW] = AW'((t - j) * M + j);
        end
      end
    end
  end

  // Disabled lanes are forced to zero. A write landing in the same cycle as
  // the bank read that feeds the first stream step is forwarded, so a write
  // issued together with start is seen by the stream.
  always_comb begin
    a_out_d = '0;
    b_out_d = '0;
    for (int i = 0; i < N; i++) begin
      if (a_en_d[i]) begin
        if (a_we && bank_match && (wr_addr == a_raddr[i*AW +: AW])) begin
          a_out_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
        end else begin
          a_out_d[i*DATA_WIDTH +: DATA_WIDTH] = a_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    for (int j = 0; j < M; j++) begin
      if (b_en_d[j]) begin
        if (b_we && bank_match && (wr_addr == b_raddr[j*AW +: AW])) begin
          b_out_d[j*DATA_WIDTH +: DATA_WIDTH] = wr_data;
        end else begin
          b_out_d[j*DATA_WIDTH +: DATA_WIDTH] = b_rdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_out_q <= '0;
      b_out_q <= '0;
      a_en_q  <= '0;
      b_en_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      a_en_q  <= a_en_d;
      b_en_q  <= b_en_d;
    end
  end

  assign A_out    = a_out_q;
  assign B_out    = b_out_q;
  assign A_en     = a_en_q;
  assign B_en     = b_en_q;
  assign busy     = (state_q == STREAM) || (state_q == ST_DRAIN);
  assign load_out = (state_q == DONE);

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Scoreboard bench for systolic_operand_feeder (N=M=K=3, T=5, drain=5).
// The driver keeps a matrix-level model of the operand banks; each accepted
// start pushes every expected stream step and the load_out cycle into queues,
// and an independent monitor pops and compares whenever the DUT presents them.
module tb_systolic_operand_feeder;
  import systolic_pkg::*;

  localparam int DW        = 32;
  localparam int N         = 3;
  localparam int M         = 3;
  localparam int K         = 3;
  localparam int AW        = 4;
  localparam int T         = K + 3 - 1;
  localparam int DRAIN_CYC = N + M - 1;
  localparam int RUN_LEN   = 1 + T + DRAIN_CYC;

  logic            clk, rst;
  logic            wr_en, wr_sel, wr_ready, start, busy, load_out;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [N*DW-1:0] A_out;
  logic [N-1:0]    A_en;
  logic [M*DW-1:0] B_out;
  logic [M-1:0]    B_en;

  systolic_operand_feeder #(.DATA_WIDTH(DW), .N(N), .M(M), .K(K)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .start(start), .busy(busy),
    .A_out(A_out), .A_en(A_en), .B_out(B_out), .B_en(B_en), .load_out(load_out)
  );

  typedef struct {
    int              cyc;
    logic [N-1:0]    a_en;
    logic [N*DW-1:0] a_out;
    logic [M-1:0]    b_en;
    logic [M*DW-1:0] b_out;
  } exp_t;

  operand_t ma [2][N*K];
  operand_t mb [2][K*M];
  int       act;
  bit       double_buf;
  exp_t     exp_q[$];
  int       load_q[$];
  exp_t     mon_rec;
  int       mon_load;
  int       cyc, run_lo, run_hi;
  int       checks, errors;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Expected stream for a run whose start is sampled in cycle c, straight from
  // the skew rule: lane i carries A[i][t-i], lane j carries B[t-j][j].
  task automatic push_run(input int c);
    for (int t = 0; t < T; t++) begin
      exp_t rec;
      rec.cyc = c + 1 + t;
      rec.a_en = '0; rec.a_out = '0; rec.b_en = '0; rec.b_out = '0;
      for (int i = 0; i < N; i++) begin
        if (t >= i && t < i + K) begin
          rec.a_en[i] = 1'b1;
          rec.a_out[i*DW +: DW] = ma[act][i*K + (t - i)];
        end
      end
      for (int j = 0; j < M; j++) begin
        if (t >= j && t < j + K) begin
          rec.b_en[j] = 1'b1;
          rec.b_out[j*DW +: DW] = mb[act][(t - j)*M + j];
        end
      end
      exp_q.push_back(rec);
    end
    load_q.push_back(c + RUN_LEN);
    run_lo = c + 1;
    run_hi = c + RUN_LEN;
  endtask

  // One clock cycle of stimulus; the model is updated in the order the
  // hardware applies it (write first, then start).
  task automatic apply_stimulus(input logic we, input logic sel, input int addr,
                                input operand_t data, input logic st);
    bit in_run, in_done, exp_ready, accept;
    int bank;
    wr_en = we; wr_sel = sel; wr_addr = AW'(addr); wr_data = data; start = st;
    in_run    = (cyc >= run_lo) && (cyc <= run_hi);
    in_done   = in_run && (cyc == run_hi);
    exp_ready = double_buf ? 1'b1 : !in_run;
    check_output("wr_ready", wr_ready, exp_ready);
    if (we && exp_ready) begin
      bank = double_buf ? 1 - act : 0;
      if (!sel && addr < N*K) ma[bank][addr] = data;
      else if (sel && addr < K*M) mb[bank][addr] = data;
    end
    accept = st && (double_buf ? (!in_run || in_done) : !in_run);
    if (accept) begin
      if (double_buf) act = 1 - act;
      push_run(cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 0, '0, 1'b0);
  endtask

  // A = 1..9 row-major, B = identity.
  task automatic load_directed();
    for (int a = 0; a < N*K; a++) apply_stimulus(1'b1, 1'b0, a, operand_t'(a + 1), 1'b0);
    for (int b = 0; b < K*M; b++) apply_stimulus(1'b1, 1'b1, b, operand_t'((b / M == b % M) ? 1 : 0), 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_busy"}, busy, 1'b0);
    check_output({tag, "_A_en"}, A_en, '0);
    check_output({tag, "_B_en"}, B_en, '0);
    check_output({tag, "_load_out"}, load_out, 1'b0);
    check_output({tag, "_wr_ready"}, wr_ready, 1'b1);
    check_output({tag, "_A_out"}, A_out, '0);
    check_output({tag, "_B_out"}, B_out, '0);
  endtask

  // Monitor: pops an expected stream step whenever any lane is enabled and an
  // expected load_out cycle whenever load_out is high.
  always @(negedge clk) begin
    if (rst) begin
      if (A_en != '0 || B_en != '0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_stream: got enables %b/%b expected none (cycle %0d)", A_en, B_en, cyc);
        end else begin
          mon_rec = exp_q.pop_front();
          check_output("stream_cycle", cyc, mon_rec.cyc);
          check_output("A_en", A_en, mon_rec.a_en);
          check_output("A_out", A_out, mon_rec.a_out);
          check_output("B_en", B_en, mon_rec.b_en);
          check_output("B_out", B_out, mon_rec.b_out);
          check_output("busy_in_stream", busy, 1'b1);
        end
      end else begin
        check_output("gated_A_out", A_out, '0);
        check_output("gated_B_out", B_out, '0);
      end
      if (load_out) begin
        if (load_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_load_out: got pulse expected none (cycle %0d)", cyc);
        end else begin
          mon_load = load_q.pop_front();
          check_output("load_cycle", cyc, mon_load);
          check_output("busy_at_load", busy, 1'b0);
        end
      end
    end
  end

  initial begin
    clk = 1'b0; rst = 1'b0; cyc = 0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    checks = 0; errors = 0; act = 0; run_lo = 1; run_hi = 0;
`ifdef FEEDER_DOUBLE_BUF_EN
    double_buf = 1'b1;
`else
    double_buf = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    idle(2);

    $display("[TB] directed run: A=1..9, B=I");
    load_directed();
    apply_stimulus(1'b0, 1'b0, 0, '0, 1'b1);
    idle(RUN_LEN + 2);

    $display("[TB] start pulses during STREAM and DRAIN");
    load_directed();
    apply_stimulus(1'b0, 1'b0, 0, '0, 1'b1);
    idle(2);
    apply_stimulus(1'b0, 1'b0, 0, '0, 1'b1);
    idle(4);
    apply_stimulus(1'b0, 1'b0, 0, '0, 1'b1);
    idle(6);

    $display("[TB] out-of-range writes");
    apply_stimulus(1'b1, 1'b0, 9, operand_t'(99), 1'b0);
    apply_stimulus(1'b1, 1'b1, 9, operand_t'(55), 1'b0);
    apply_stimulus(1'b0, 1'b0, 0, '0, 1'b1);
    idle(RUN_LEN + 2);

    $display("[TB] write during STREAM, start in DONE");
    apply_stimulus(1'b0, 1'b0, 0, '0, 1'b1);
    idle(1);
    apply_stimulus(1'b1, 1'b0, 0, operand_t'(42), 1'b0);
    idle(8);
    apply_stimulus(1'b0, 1'b0, 0, '0, 1'b1);
    idle(RUN_LEN + 3);

    $display("[TB] write and start in the same cycle");
    load_directed();
    apply_stimulus(1'b1, 1'b0, 0, operand_t'(7), 1'b1);
    idle(RUN_LEN + 2);

    $display("[TB] reset mid-stream");
    apply_stimulus(1'b0, 1'b0, 0, '0, 1'b1);
    idle(4);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    load_q.delete();
    act = 0; run_lo = 1; run_hi = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 240; r++) begin
      apply_stimulus(($urandom % 3) == 0, 1'($urandom % 2), int'($urandom_range(0, 10)),
                     operand_t'($urandom), ($urandom % 9) == 0);
    end
    idle(RUN_LEN + 4);

    check_output("stream_queue_empty", exp_q.size(), 0);
    check_output("load_queue_empty", load_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
